ntt_stream_wrapper: RTL

- Streaming front/back end for the parallel NTT/INTT processing unit (D coefficients × N bits).
- Load side: collects D coefficients one per cycle over a valid/ready interface and packs them into the PU's parallel input bus. It then sequences the PU's reset/stage counter for LAT cycles.
- Unload side: captures the PU's parallel result and streams it out one coefficient per cycle with backpressure.
- Sits directly upstream and downstream of the PU: drives its a/inv/rst inputs and consumes its an output.

---
 rtl/ntt_stream_wrapper_if.sv | 24 ++
 rtl/ntt_stream_wrapper.sv | 110 +++++++++++
 2 files changed

// File: rtl/ntt_stream_wrapper_if.sv
// Streaming coefficient bus for the NTT wrapper: a load stream in and a result stream out.
// The wrapper connects through the slave modport, and the traffic source/sink through the master modport.
interface ntt_stream_wrapper_if #(
  parameter int unsigned N = 17
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_last;

  modport master (
    output in_valid, in_data, in_inv, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_inv, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/ntt_stream_wrapper.sv
// Serial-to-parallel loader and parallel-to-serial unloader around the NTT/INTT processing unit.
// The load buffer drives pu_a directly, so it is written only in LOAD and held through KICK and RUN.
module ntt_stream_wrapper #(
  parameter int unsigned N   = 17,
  parameter int unsigned D   = 16,
  parameter int unsigned LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ntt_stream_wrapper_if.slave   s,
  output logic                  busy,
  output logic [D*N-1:0]        pu_a,
  output logic                  pu_inv,
  output logic                  pu_rst,
  input  logic [D*N-1:0]        pu_an
);
  localparam int unsigned IW = $clog2(D);
  localparam int unsigned RW = $clog2(LAT + 1);

  typedef enum logic [1:0] {LOAD, KICK, RUN, DRAIN} state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  in_idx_q, in_idx_d;
  logic [IW-1:0]  out_idx_q, out_idx_d;
  logic [RW-1:0]  run_cnt_q, run_cnt_d;
  logic [D*N-1:0] abuf_q, abuf_d;
  logic [D*N-1:0] obuf_q, obuf_d;
  logic           inv_q, inv_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD;
      in_idx_q  <= '0;
      out_idx_q <= '0;
      run_cnt_q <= '0;
      abuf_q    <= '0;
      obuf_q    <= '0;
      inv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_idx_q  <= in_idx_d;
      out_idx_q <= out_idx_d;
      run_cnt_q <= run_cnt_d;
      abuf_q    <= abuf_d;
      obuf_q    <= obuf_d;
      inv_q     <= inv_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_idx_d  = in_idx_q;
    out_idx_d = out_idx_q;
    run_cnt_d = run_cnt_q;
    abuf_d    = abuf_q;
    obuf_d    = obuf_q;
    inv_d     = inv_q;
    case (state_q)
      LOAD: begin
        if (s.in_valid && s.in_ready) begin
          abuf_d[in_idx_q*N +: N] = s.in_data;
          if (in_idx_q == '0) inv_d = s.in_inv;
          if (in_idx_q == IW'(D - 1)) begin
            in_idx_d = '0;
            state_d  = KICK;
          end else begin
            in_idx_d = in_idx_q + 1'b1;
          end
        end
      end
      KICK: begin
        run_cnt_d = '0;
        state_d   = RUN;
      end
      RUN: begin
        run_cnt_d = run_cnt_q + 1'b1;
        // Capture on run_cnt == LAT: the PU gets LAT full cycles after pu_rst drops, and the
        // first output appears LAT+2 cycles after the final input handshake.
        if (run_cnt_q == RW'(LAT)) begin
          obuf_d    = pu_an;
          out_idx_d = '0;
          run_cnt_d = '0;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (s.out_valid && s.out_ready) begin
          if (out_idx_q == IW'(D - 1)) begin
            out_idx_d = '0;
            state_d   = LOAD;
          end else begin
            out_idx_d = out_idx_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    s.in_ready  = !rst && (state_q == LOAD);
    s.out_valid = !rst && (state_q == DRAIN);
    s.out_data  = obuf_q[out_idx_q*N +: N];
    s.out_last  = s.out_valid && (out_idx_q == IW'(D - 1));
    busy        = !rst && ((state_q != LOAD) || (in_idx_q != '0));
    pu_rst      = rst || (state_q == KICK);
    pu_a        = abuf_q;
    pu_inv      = inv_q;
  end
endmodule
